ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register; directly consumes ID/EX register outputs.
//  Forwards operands from EX/MEM and MEM/WB, runs the ALU, registers results for MEM.
//  Detects load-use hazards: drives ST (bubble) into ID/EX and a hold to PC and IF/ID.
// PARAMETERS
//  DW  32  datapath width (RD1/RD2/SgnIMM/PC/results)
//  RW  4   register-number width (WN/RN1/RN2)
// PORTS
//  Clk            in   1   clock; all state updates on posedge
//  RstN           in   1   asynchronous reset, active-low
//  ID_EX_ALUSrcB  in   1   1: ALU B = SgnIMM; 0: forwarded RD2
//  ID_EX_MReg     in   1   MEM->WB result select, passed through
//  ID_EX_EnRW     in   1   register write enable, passed through
//  ID_EX_MR/MW    in   1   memory read / write, passed through
//  ID_EX_ALUOp    in   2   ALU operation (see BEHAVIOUR)
//  ID_EX_WN       in   RW  destination register
//  ID_EX_RN1/RN2  in   RW  source registers (for forwarding)
//  ID_EX_RD1/RD2  in   DW  register-file read data
//  ID_EX_PC       in   DW  instruction PC, passed through
//  ID_EX_SgnIMM   in   DW  sign-extended immediate
//  IF_ID_RN1/RN2  in   RW  sources of instruction in decode (hazard check)
//  MEM_WB_EnRW    in   1   WB write enable
//  MEM_WB_WN      in   RW  WB destination
//  MEM_WB_WD      in   DW  WB write data (post MReg mux)
//  EX_MEM_ALURes  out  DW  registered ALU result / memory address
//  EX_MEM_WD      out  DW  registered store data (forwarded RD2)
//  EX_MEM_PC      out  DW  registered PC
//  EX_MEM_WN      out  RW  registered destination
//  EX_MEM_EnRW, EX_MEM_MReg, EX_MEM_MR, EX_MEM_MW  out 1  registered controls
//  EX_MEM_Zero    out  1   registered (ALU result == 0)
//  ST             out  1   bubble request to ID/EX (combinational)
//  Hold           out  1   freeze PC and IF/ID (combinational, equals ST)
// BEHAVIOUR
//  Reset (RstN=0, async): every EX_MEM_* output 0; Vld flag 0; ST=Hold=0.
//  Vld: internal reg, set 1 on first Clk edge after RstN rises. While Vld=0, EX/MEM
//   captures a bubble (all zeros) and ST/Hold are forced 0 (ID/EX contents undefined).
//  Forward A (B identical with RN2/RD2), priority high->low:
//   1) EX_MEM_EnRW & !EX_MEM_MR & EX_MEM_WN==ID_EX_RN1 -> EX_MEM_ALURes
//   2) MEM_WB_EnRW & MEM_WB_WN==ID_EX_RN1              -> MEM_WB_WD
//   3) otherwise ID_EX_RD1. No register is special; R0 forwards like any other.
//  ALU B = ALUSrcB ? SgnIMM : fwdB. Store data = fwdB regardless of ALUSrcB.
//  ALUOp: 00 ADD, 01 SUB, 10 AND, 11 OR; DW-bit wrap-around, no carry/overflow out.
//  Latency: 1 cycle ID/EX -> EX/MEM; every valid cycle loads EX/MEM (no enable).
//  Load-use: ST=Hold=Vld & ID_EX_MR & (ID_EX_WN==IF_ID_RN1 | ID_EX_WN==IF_ID_RN2).
//   Asserted for exactly one cycle per load (next cycle ID/EX holds the bubble).
//   Load result reaches the dependent instruction via MEM/WB path (rule 2).
//  Simultaneous EX/MEM and MEM/WB match: EX/MEM wins (youngest producer).
//  EX/MEM load with matching WN is never forwarded (data not yet available).
//  RstN low mid-operation: EX/MEM cleared immediately; in-flight instruction dropped.
// STRUCTURE
//  Shared package: ALUOp codes (ALU_ADD..ALU_OR), forwarding select codes
//   (FWD_RF=00, FWD_WB=01, FWD_MEM=10), DW/RW defaults.
//  One sub-module: ex_alu (combinational; a, b, op -> result, zero).
//  Forwarding muxes, hazard compare, Vld and EX/MEM register stay in this module.
// TESTING
//  1) RstN=0 mid-stream -> all EX_MEM_* 0 same cycle; first edge after release is bubble.
//  2) R1=5,R2=3: SUB R3,R1,R2 -> EX_MEM_ALURes=2, Zero=0; SUB R4,R1,R1 -> 0, Zero=1.
//  3) ADD R3=R1+R2 (8) then AND R5,R3,R3 back-to-back -> EX/MEM forward, ALURes=8.
//  4) Same dest R3 in EX/MEM (=8) and MEM/WB (=7) -> consumer sees 8.
//  5) LD R6 then ADD R7,R6,R1 -> ST=Hold=1 one cycle; WB data 0x10 forwarded, ALURes=0x15.
//  6) ST with RD2 stale, producer in MEM/WB=0xDEAD, ALUSrcB=1 -> EX_MEM_WD=0xDEAD.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, operand
// forwarding select codes and default datapath widths.
package ex_mem_stage_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // EX/MEM is the youngest producer, so it wins over MEM/WB
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    fwd_sel_e sel;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Combinational execute-stage ALU: wrap-around add/sub and bitwise and/or,
// with a zero flag on the result.
module ex_alu
  import ex_mem_stage_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] result,
  output logic          zero
);

  // operation select
  always_comb begin
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, load-use hazard detection and the
// EX/MEM pipeline register feeding the memory stage.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          ID_EX_ALUSrcB,
  input  logic          ID_EX_MReg,
  input  logic          ID_EX_EnRW,
  input  logic          ID_EX_MR,
  input  logic          ID_EX_MW,
  input  logic [1:0]    ID_EX_ALUOp,
  input  logic [RW-1:0] ID_EX_WN,
  input  logic [RW-1:0] ID_EX_RN1,
  input  logic [RW-1:0] ID_EX_RN2,
  input  logic [DW-1:0] ID_EX_RD1,
  input  logic [DW-1:0] ID_EX_RD2,
  input  logic [DW-1:0] ID_EX_PC,
  input  logic [DW-1:0] ID_EX_SgnIMM,
  input  logic [RW-1:0] IF_ID_RN1,
  input  logic [RW-1:0] IF_ID_RN2,
  input  logic          MEM_WB_EnRW,
  input  logic [RW-1:0] MEM_WB_WN,
  input  logic [DW-1:0] MEM_WB_WD,
  output logic [DW-1:0] EX_MEM_ALURes,
  output logic [DW-1:0] EX_MEM_WD,
  output logic [DW-1:0] EX_MEM_PC,
  output logic [RW-1:0] EX_MEM_WN,
  output logic          EX_MEM_EnRW,
  output logic          EX_MEM_MReg,
  output logic          EX_MEM_MR,
  output logic          EX_MEM_MW,
  output logic          EX_MEM_Zero,
  output logic          ST,
  output logic          Hold
);

  logic          vld_r;
  fwd_sel_e      fwd_a_sel_s;
  fwd_sel_e      fwd_b_sel_s;
  logic [DW-1:0] fwd_a_s;
  logic [DW-1:0] fwd_b_s;
  logic [DW-1:0] alu_b_s;
  logic [DW-1:0] alu_res_s;
  logic          alu_zero_s;
  logic          load_use_s;

  // A load sitting in EX/MEM has no data yet, so it is never a forwarding source
  assign fwd_a_sel_s = fwd_select(EX_MEM_EnRW & ~EX_MEM_MR & (EX_MEM_WN == ID_EX_RN1),
                                  MEM_WB_EnRW & (MEM_WB_WN == ID_EX_RN1));
  assign fwd_b_sel_s = fwd_select(EX_MEM_EnRW & ~EX_MEM_MR & (EX_MEM_WN == ID_EX_RN2),
                                  MEM_WB_EnRW & (MEM_WB_WN == ID_EX_RN2));

  // operand A forwarding mux
  always_comb begin
    case (fwd_a_sel_s)
      FWD_MEM: fwd_a_s = EX_MEM_ALURes;
      FWD_WB:  fwd_a_s = MEM_WB_WD;
      FWD_RF:  fwd_a_s = ID_EX_RD1;
      default: fwd_a_s = ID_EX_RD1;
    endcase
  end

  // operand B forwarding mux
  always_comb begin
    case (fwd_b_sel_s)
      FWD_MEM: fwd_b_s = EX_MEM_ALURes;
      FWD_WB:  fwd_b_s = MEM_WB_WD;
      FWD_RF:  fwd_b_s = ID_EX_RD2;
      default: fwd_b_s = ID_EX_RD2;
    endcase
  end

  // ALU B source: immediate or forwarded register
  always_comb begin
    if (ID_EX_ALUSrcB) begin
      alu_b_s = ID_EX_SgnIMM;
    end else begin
      alu_b_s = fwd_b_s;
    end
  end

  ex_alu #(.DW(DW)) u_alu (
    .a      (fwd_a_s),
    .b      (alu_b_s),
    .op     (alu_op_e'(ID_EX_ALUOp)),
    .result (alu_res_s),
    .zero   (alu_zero_s)
  );

  assign load_use_s = vld_r & ID_EX_MR &
                      ((ID_EX_WN == IF_ID_RN1) | (ID_EX_WN == IF_ID_RN2));
  assign ST   = load_use_s;
  assign Hold = load_use_s;

  // ID/EX contents are meaningless until the first edge after reset release
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      vld_r <= 1'b0;
    end else begin
      vld_r <= 1'b1;
    end
  end

  // EX/MEM pipeline register, bubble while not yet valid
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      EX_MEM_ALURes <= '0;
      EX_MEM_WD     <= '0;
      EX_MEM_PC     <= '0;
      EX_MEM_WN     <= '0;
      EX_MEM_EnRW   <= 1'b0;
      EX_MEM_MReg   <= 1'b0;
      EX_MEM_MR     <= 1'b0;
      EX_MEM_MW     <= 1'b0;
      EX_MEM_Zero   <= 1'b0;
    end else if (!vld_r) begin
      EX_MEM_ALURes <= '0;
      EX_MEM_WD     <= '0;
      EX_MEM_PC     <= '0;
      EX_MEM_WN     <= '0;
      EX_MEM_EnRW   <= 1'b0;
      EX_MEM_MReg   <= 1'b0;
      EX_MEM_MR     <= 1'b0;
      EX_MEM_MW     <= 1'b0;
      EX_MEM_Zero   <= 1'b0;
    end else begin
      EX_MEM_ALURes <= alu_res_s;
      EX_MEM_WD     <= fwd_b_s;
      EX_MEM_PC     <= ID_EX_PC;
      EX_MEM_WN     <= ID_EX_WN;
      EX_MEM_EnRW   <= ID_EX_EnRW;
      EX_MEM_MReg   <= ID_EX_MReg;
      EX_MEM_MR     <= ID_EX_MR;
      EX_MEM_MW     <= ID_EX_MW;
      EX_MEM_Zero   <= alu_zero_s;
    end
  end

endmodule
